// File: rtl/os_cs_drain_resolver.sv
// os_cs_drain_resolver
//
// Purpose:
//   Drains the carry-save accumulators of one column of output-stationary MAC
//   PEs. On drain_start_i every (sum, carry) pair is snapshotted. The pairs are
//   then streamed out one per cycle, index 0 first, as resolved two's-complement
//   sums. The resolve step is a carry-propagate adder split across two register
//   stages, and the output uses a valid/ready handshake. A one-cycle pe_clear_o
//   lets the PEs start the next tile while the drain is still running.
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   drain_start_i  single-cycle request to snapshot and drain (ignored unless idle)
//   pe_acc_sum_i   PE sum vectors, PE i at [i*ACC_WIDTH +: ACC_WIDTH]
//   pe_acc_carry_i PE carry vectors, same packing
//   pe_clear_o     one-cycle pulse after the capture edge
//   drain_busy_o   high from the capture edge through the drain_done_o cycle
//   out_valid_o    out_data_o/out_index_o/out_last_o are valid
//   out_ready_i    downstream accepts
//   out_data_o     resolved sum + carry, modulo 2^ACC_WIDTH
//   out_index_o    source PE index of out_data_o
//   out_last_o     high with the element from PE NUM_PE-1
//   drain_done_o   one-cycle pulse after the last handshake
//
// States:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for drain_start_i; snapshot is captured on leaving
//   S_STREAM | issuing snapshot entries into the pipeline / emitting output
//   S_DONE   | last element accepted; drain_done_o high for this one cycle

module os_cs_drain_resolver #(
  parameter int NUM_PE    = 8,
  parameter int ACC_WIDTH = 32,
  parameter int IDX_W     = $clog2(NUM_PE)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        drain_start_i,
  input  logic [NUM_PE*ACC_WIDTH-1:0] pe_acc_sum_i,
  input  logic [NUM_PE*ACC_WIDTH-1:0] pe_acc_carry_i,
  output logic                        pe_clear_o,
  output logic                        drain_busy_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [ACC_WIDTH-1:0]        out_data_o,
  output logic [IDX_W-1:0]            out_index_o,
  output logic                        out_last_o,
  output logic                        drain_done_o
);

  localparam int H = ACC_WIDTH / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                 state_q;

  logic [ACC_WIDTH-1:0]   snap_sum_q   [NUM_PE];
  logic [ACC_WIDTH-1:0]   snap_carry_q [NUM_PE];
  logic [IDX_W-1:0]       ptr_q;
  logic                   issued_all_q;

  // Stage 1: low half resolved, high halves still unresolved.
  logic                   s1_valid_q;
  logic [H-1:0]           s1_lo_q;
  logic                   s1_c_q;
  logic [H-1:0]           s1_sum_hi_q;
  logic [H-1:0]           s1_carry_hi_q;
  logic [IDX_W-1:0]       s1_idx_q;
  logic                   s1_last_q;

  // Output register.
  logic                   out_valid_q;
  logic [ACC_WIDTH-1:0]   out_data_q;
  logic [IDX_W-1:0]       out_index_q;
  logic                   out_last_q;

  logic                   pe_clear_q;
  logic                   drain_busy_q;
  logic                   drain_done_q;

  // Combinational next values for the pipeline stages.
  logic                   stall;
  logic                   issue;
  logic                   accept_last;
  logic [ACC_WIDTH-1:0]   iss_sum;
  logic [ACC_WIDTH-1:0]   iss_carry;
  logic [H:0]             s1_lo_full_d;
  logic [H-1:0]           out_hi_d;

  always_comb begin
    stall        = out_valid_q & ~out_ready_i;
    issue        = (state_q == S_STREAM) & ~issued_all_q & ~stall;
    accept_last  = out_valid_q & out_ready_i & out_last_q;
    iss_sum      = snap_sum_q[ptr_q];
    iss_carry    = snap_carry_q[ptr_q];
    // One extra bit keeps the carry out of the low half for stage 2.
    s1_lo_full_d = {1'b0, iss_sum[H-1:0]} + {1'b0, iss_carry[H-1:0]};
    // High half wraps: bits beyond ACC_WIDTH are dropped by design.
    out_hi_d     = s1_sum_hi_q + s1_carry_hi_q + {{(H-1){1'b0}}, s1_c_q};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < NUM_PE; i++) begin
        snap_sum_q[i]   <= '0;
        snap_carry_q[i] <= '0;
      end
      ptr_q         <= '0;
      issued_all_q  <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c_q        <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s1_idx_q      <= '0;
      s1_last_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_last_q    <= 1'b0;
      pe_clear_q    <= 1'b0;
      drain_busy_q  <= 1'b0;
      drain_done_q  <= 1'b0;
    end else begin
      pe_clear_q   <= 1'b0;
      drain_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (drain_start_i) begin
            for (int i = 0; i < NUM_PE; i++) begin
              snap_sum_q[i]   <= pe_acc_sum_i[i*ACC_WIDTH +: ACC_WIDTH];
              snap_carry_q[i] <= pe_acc_carry_i[i*ACC_WIDTH +: ACC_WIDTH];
            end
            ptr_q        <= '0;
            issued_all_q <= 1'b0;
            drain_busy_q <= 1'b1;
            pe_clear_q   <= 1'b1;
            state_q      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept_last) begin
            drain_done_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          drain_busy_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          drain_busy_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase

      // Issue pointer only advances in S_STREAM, so it never collides with
      // the reset-to-zero done on capture.
      if (issue) begin
        if (ptr_q == LAST_IDX) begin
          issued_all_q <= 1'b1;
        end else begin
          ptr_q <= ptr_q + IDX_W'(1);
        end
      end

      // A stall freezes both pipeline stages so the output holds stable.
      if (!stall) begin
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_valid_q & s1_last_q;
        if (s1_valid_q) begin
          out_data_q  <= {out_hi_d, s1_lo_q};
          out_index_q <= s1_idx_q;
        end

        s1_valid_q <= issue;
        if (issue) begin
          s1_lo_q       <= s1_lo_full_d[H-1:0];
          s1_c_q        <= s1_lo_full_d[H];
          s1_sum_hi_q   <= iss_sum[ACC_WIDTH-1:H];
          s1_carry_hi_q <= iss_carry[ACC_WIDTH-1:H];
          s1_idx_q      <= ptr_q;
          s1_last_q     <= (ptr_q == LAST_IDX);
        end
      end
    end
  end

  assign pe_clear_o   = pe_clear_q;
  assign drain_busy_o = drain_busy_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_index_o  = out_index_q;
  assign out_last_o   = out_last_q;
  assign drain_done_o = drain_done_q;

endmodule

// File: tb/tb_os_cs_drain_resolver.sv
// Self-checking bench for os_cs_drain_resolver. Expected elements are queued
// when a drain is started and compared as the DUT hands them off.

module tb_os_cs_drain_resolver;

  localparam int NUM_PE = 8;
  localparam int W      = 32;
  localparam int IDX_W  = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  drain_start;
  logic [NUM_PE*W-1:0]   pe_sum;
  logic [NUM_PE*W-1:0]   pe_carry;
  logic                  pe_clear;
  logic                  drain_busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic                  drain_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]     data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t sb[$];

  int hs_count    = 0;
  int clear_count = 0;
  int done_count  = 0;
  int ready_mode  = 0;  // 0: always ready, 1: 1,0,0 pattern, 2: random
  int rdy_phase   = 0;

  always #5 clk = ~clk;

  os_cs_drain_resolver #(
    .NUM_PE(NUM_PE), .ACC_WIDTH(W), .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .drain_start_i(drain_start),
    .pe_acc_sum_i(pe_sum), .pe_acc_carry_i(pe_carry),
    .pe_clear_o(pe_clear), .drain_busy_o(drain_busy),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_index_o(out_index),
    .out_last_o(out_last), .drain_done_o(drain_done)
  );

  // out_ready changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        out_ready = (rdy_phase == 0);
        rdy_phase = (rdy_phase + 1) % 3;
      end
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Scoreboard monitor: at the falling edge, valid&ready means the element is
  // taken at the next rising edge.
  logic             prev_stall = 1'b0;
  logic [W-1:0]     prev_data;
  logic [IDX_W-1:0] prev_idx;
  logic             prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data ||
            out_index !== prev_idx || out_last !== prev_last) begin
          failures++;
          $display("FAIL stall_hold: got v=%0b d=%h i=%0d l=%0b want v=1 d=%h i=%0d l=%0b",
                   out_valid, out_data, out_index, out_last, prev_data, prev_idx, prev_last);
        end
      end
      if (pe_clear === 1'b1) clear_count++;
      if (drain_done === 1'b1) done_count++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        hs_count++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got d=%h i=%0d, want no element", out_data, out_index);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_index !== e.idx || out_last !== e.last) begin
            failures++;
            $display("FAIL element: got d=%h i=%0d l=%0b want d=%h i=%0d l=%0b",
                     out_data, out_index, out_last, e.data, e.idx, e.last);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      prev_last  = out_last;
    end
  end

  // Drives one drain_start pulse and queues the expected elements. Returns
  // one time unit after the capture edge E0.
  task automatic start_drain(input logic [NUM_PE*W-1:0] s,
                             input logic [NUM_PE*W-1:0] c,
                             input logic [NUM_PE*W-1:0] e);
    exp_t x;
    @(posedge clk); #1;
    pe_sum      = s;
    pe_carry    = c;
    drain_start = 1'b1;
    for (int i = 0; i < NUM_PE; i++) begin
      x.data = e[i*W +: W];
      x.idx  = IDX_W'(i);
      x.last = (i == NUM_PE - 1);
      sb.push_back(x);
    end
    @(posedge clk); #1;
    drain_start = 1'b0;
  endtask

  // Waits (bounded) for drain_done, then one more cycle so the DUT is idle.
  task automatic wait_done(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (drain_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drain_start = 1'b0; out_ready = 1'b1;
    pe_sum = '0; pe_carry = '0;
    #3;
    checks++;
    if ({out_valid, drain_busy, pe_clear, drain_done, out_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000",
               {out_valid, drain_busy, pe_clear, drain_done, out_last});
    end
    checks++;
    if (out_data !== '0 || out_index !== '0) begin
      failures++;
      $display("FAIL reset_data: got d=%h i=%0d want 0", out_data, out_index);
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [NUM_PE*W-1:0] s, c, e;
    int clr_hits = 0, clr_k = -1, first_valid = -1, done_hits = 0, done_k = -1;
    bit busy_ok = 1'b1;
    int hs0;
    ready_mode = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      s[i*W +: W] = W'(i * 32'h100);
      c[i*W +: W] = W'(i);
      e[i*W +: W] = W'(i * 32'h101);
    end
    hs0 = hs_count;
    start_drain(s, c, e);
    for (int k = 0; k < 15; k++) begin
      if (pe_clear === 1'b1) begin clr_hits++; clr_k = k; end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = k;
      if (drain_done === 1'b1) begin done_hits++; done_k = k; end
      if ((k <= 10) !== (drain_busy === 1'b1)) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (clr_hits !== 1 || clr_k !== 0) begin
      failures++;
      $display("FAIL basic_pe_clear: got hits=%0d at=%0d want hits=1 at=0", clr_hits, clr_k);
    end
    checks++;
    if (first_valid !== 2) begin
      failures++;
      $display("FAIL basic_latency: got first valid %0d cycles after capture, want 2", first_valid);
    end
    checks++;
    if (done_hits !== 1 || done_k !== 10) begin
      failures++;
      $display("FAIL basic_done: got hits=%0d at=%0d want hits=1 at=10", done_hits, done_k);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL basic_busy: got wrong busy profile, want high cycles 0..10 only");
    end
    checks++;
    if (hs_count - hs0 !== NUM_PE || sb.size() !== 0) begin
      failures++;
      $display("FAIL basic_count: got hs=%0d left=%0d want hs=8 left=0", hs_count - hs0, sb.size());
    end
  endtask

  task automatic test_cross_half();
    logic [NUM_PE*W-1:0] s, c, e;
    bit seen;
    ready_mode = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      s[i*W +: W] = $urandom;
      c[i*W +: W] = $urandom;
      e[i*W +: W] = s[i*W +: W] + c[i*W +: W];
    end
    s[0*W +: W] = 32'h0000FFFF; c[0*W +: W] = 32'h00000001; e[0*W +: W] = 32'h00010000;
    s[1*W +: W] = 32'hFFFFFFFF; c[1*W +: W] = 32'h00000001; e[1*W +: W] = 32'h00000000;
    s[2*W +: W] = 32'hFFFFFF80; c[2*W +: W] = 32'h00000000; e[2*W +: W] = 32'hFFFFFF80;
    s[3*W +: W] = 32'h7FFF8000; c[3*W +: W] = 32'h00008000; e[3*W +: W] = 32'h80000000;
    start_drain(s, c, e);
    wait_done(40, seen);
    checks++;
    if (!seen || sb.size() !== 0) begin
      failures++;
      $display("FAIL cross_half_done: got done=%0b left=%0d want done=1 left=0", seen, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_PE*W-1:0] s, c, e;
    bit seen;
    int hs0;
    rdy_phase  = 0;
    ready_mode = 1;
    for (int i = 0; i < NUM_PE; i++) begin
      s[i*W +: W] = $urandom;
      c[i*W +: W] = $urandom;
      e[i*W +: W] = s[i*W +: W] + c[i*W +: W];
    end
    hs0 = hs_count;
    start_drain(s, c, e);
    wait_done(100, seen);
    checks++;
    if (!seen || hs_count - hs0 !== NUM_PE || sb.size() !== 0) begin
      failures++;
      $display("FAIL backpressure: got done=%0b hs=%0d left=%0d want done=1 hs=8 left=0",
               seen, hs_count - hs0, sb.size());
    end
    ready_mode = 0;
  endtask

  task automatic test_isolation();
    logic [NUM_PE*W-1:0] s, c, e;
    bit seen;
    int clr0, done0;
    ready_mode = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      s[i*W +: W] = 32'h1000_0000 + W'(i * 7);
      c[i*W +: W] = 32'h0000_0300 + W'(i);
      e[i*W +: W] = s[i*W +: W] + c[i*W +: W];
    end
    clr0  = clear_count;
    done0 = done_count;
    start_drain(s, c, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pe_sum      = {NUM_PE{32'hDEADBEEF}};
    pe_carry    = {NUM_PE{32'hDEADBEEF}};
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    wait_done(40, seen);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!seen || sb.size() !== 0) begin
      failures++;
      $display("FAIL isolation_done: got done=%0b left=%0d want done=1 left=0", seen, sb.size());
    end
    checks++;
    if (clear_count - clr0 !== 1 || done_count - done0 !== 1) begin
      failures++;
      $display("FAIL isolation_pulses: got clears=%0d dones=%0d want 1 and 1",
               clear_count - clr0, done_count - done0);
    end
  endtask

  task automatic test_reset_mid();
    logic [NUM_PE*W-1:0] s, c, e;
    bit seen, reached;
    int hs0, done0;
    ready_mode = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      s[i*W +: W] = $urandom;
      c[i*W +: W] = $urandom;
      e[i*W +: W] = s[i*W +: W] + c[i*W +: W];
    end
    hs0 = hs_count;
    start_drain(s, c, e);
    reached = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (hs_count - hs0 >= 3) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL reset_mid_progress: got hs=%0d want 3", hs_count - hs0);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, drain_busy, pe_clear, drain_done, out_last} !== 5'b0 ||
        out_data !== '0 || out_index !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: got flags=%b d=%h i=%0d want all 0",
               {out_valid, drain_busy, pe_clear, drain_done, out_last}, out_data, out_index);
    end
    sb.delete();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    hs0   = hs_count;
    done0 = done_count;
    start_drain(s, c, e);
    wait_done(40, seen);
    checks++;
    if (!seen || hs_count - hs0 !== NUM_PE || done_count - done0 !== 1 || sb.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_redrain: got done=%0b hs=%0d dones=%0d left=%0d want 1 8 1 0",
               seen, hs_count - hs0, done_count - done0, sb.size());
    end
  endtask

  task automatic test_random();
    logic [NUM_PE*W-1:0] s, c, e;
    logic [W-1:0]        ps, pc, p32, rsum, ns, nc;
    logic signed [7:0]   a8, b8;
    logic signed [15:0]  p16;
    bit seen;
    int timeouts = 0;
    int hs0;
    ready_mode = 2;
    hs0 = hs_count;
    for (int d = 0; d < 1000; d++) begin
      for (int i = 0; i < NUM_PE; i++) begin
        ps = '0; pc = '0; rsum = '0;
        for (int n = 0; n < int'($urandom_range(1, 8)); n++) begin
          a8  = 8'($urandom);
          b8  = 8'($urandom);
          p16 = a8 * b8;
          p32 = {{16{p16[15]}}, p16};
          rsum = rsum + p32;
          ns = ps ^ pc ^ p32;
          nc = ((ps & pc) | (ps & p32) | (pc & p32)) << 1;
          ps = ns;
          pc = nc;
        end
        s[i*W +: W] = ps;
        c[i*W +: W] = pc;
        e[i*W +: W] = rsum;
      end
      start_drain(s, c, e);
      wait_done(200, seen);
      if (!seen) timeouts++;
    end
    checks++;
    if (timeouts !== 0 || hs_count - hs0 !== 1000 * NUM_PE || sb.size() !== 0) begin
      failures++;
      $display("FAIL random_drains: got timeouts=%0d hs=%0d left=%0d want 0 %0d 0",
               timeouts, hs_count - hs0, sb.size(), 1000 * NUM_PE);
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cross_half();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/os_cs_drain_resolver.md
Name: os_cs_drain_resolver

Overview:
- Drains the carry-save accumulators (acc_sum, acc_carry) of one column of NUM_PE output-stationary MAC PEs after accumulation completes.
- Snapshots all pairs, then streams them out one per cycle as resolved two's-complement full sums through a 2-stage split carry-propagate adder.
- Output uses a valid/ready handshake. Pulses a clear to the PEs so the next tile can accumulate while the drain proceeds.

Parameters:
- NUM_PE, 8, number of PEs in the column (>=2)
- ACC_WIDTH, 32, accumulator width; must be even
- IDX_W, $clog2(NUM_PE), width of out_index

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- drain_start  input  1  single-cycle request to snapshot and drain
- pe_acc_sum  input  NUM_PE*ACC_WIDTH  PE sum vectors; PE i at bits [i*ACC_WIDTH +: ACC_WIDTH]
- pe_acc_carry  input  NUM_PE*ACC_WIDTH  PE carry vectors, same packing
- pe_clear  output  1  one-cycle pulse telling the PEs to zero their accumulators
- drain_busy  output  1  high from the capture edge until the drain_done cycle inclusive
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts
- out_data  output  ACC_WIDTH  resolved sum+carry, modulo 2^ACC_WIDTH
- out_index  output  IDX_W  PE index of out_data
- out_last  output  1  high with the element from PE NUM_PE-1
- drain_done  output  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; snapshot and pipeline registers 0.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - If drain_start is sampled high, capture all NUM_PE sum/carry pairs into snapshot registers on that edge (E0).
  - Set issue pointer to 0; go to STREAM; drain_busy=1 from E0.
  - pe_clear=1 for exactly the cycle after E0.
- STREAM, issue:
  - Each cycle the pipeline is not stalled, issue snapshot[ptr] into stage 1 and increment ptr.
  - Stop issuing after ptr=NUM_PE-1 is issued.
- Stage 1 (registered):
  - lo = sum[H-1:0] + carry[H-1:0], H = ACC_WIDTH/2.
  - Register lo[H-1:0], carry-out c, both high halves, index, and a last flag.
- Stage 2 / output register:
  - out_data = {sum_hi + carry_hi + c, lo}.
  - Discard bits beyond ACC_WIDTH (wrap, no saturation).
- Latency: element 0 is issued at E1 and appears on out_valid after E2. With out_ready held high, one element per cycle; out_last with index NUM_PE-1 follows after E(NUM_PE+1).
- Stall:
  - stall = out_valid & ~out_ready. A stall freezes stage 1, the output register and ptr.
  - out_data, out_index and out_last hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- Bubbles: out_valid=0 when no element is present. out_ready while out_valid=0 has no effect.
- DONE:
  - Entered on the handshake of the out_last element; out_valid drops next cycle unless another element is present (it cannot be).
  - drain_done=1 for one cycle in DONE; drain_busy also =1 in that cycle.
  - Then return to IDLE; the next drain_start is accepted the following cycle.
- drain_start while not IDLE is ignored: no re-capture, no extra pe_clear.
- Snapshot isolation: PE inputs are read only at E0. Changes on pe_acc_* after E0, including the PE clear, do not affect the drained values.
- Reset mid-drain: immediately abort. out_valid=0, drain_busy=0, no drain_done; the remaining elements are lost.
- The element order is always index 0..NUM_PE-1. out_index matches the source PE exactly.

Test Plan:
- Basic drain, NUM_PE=8, out_ready=1:
  - Stimulus: PE i sum=i*0x100, carry=i.
  - Response: out_data=i*0x101 with index i on 8 consecutive cycles; first valid 2 cycles after the capture edge; out_last on index 7; drain_done 1 cycle after; pe_clear exactly 1 cycle after capture.
- Cross-half carry:
  - Stimulus: sum=0x0000FFFF, carry=0x00000001 -> out_data=0x00010000.
  - Stimulus: sum=0xFFFFFFFF, carry=0x00000001 -> 0x00000000 (wrap).
  - Stimulus: sum=0xFFFFFF80, carry=0 -> 0xFFFFFF80 (-128).
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... during the drain.
  - Response: out_data, out_index and out_last stable while stalled; all 8 elements delivered in order, none duplicated.
- Snapshot isolation / ignored start:
  - Stimulus: change all pe_acc_* to 0xDEADBEEF and pulse drain_start mid-drain.
  - Response: the original captured values are delivered; no second pe_clear; a single drain_done.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 after 3 handshakes.
  - Response: all outputs 0 asynchronously; a new drain_start after release performs a full 8-element drain.
- Randomized against a reference:
  - Stimulus: 1000 drains, random 8-bit x 8-bit products accumulated in carry-save form, random out_ready.
  - Response: each out_data equals the signed reference accumulation modulo 2^32.
